// File: rtl/mux_chan_sched_pkg.sv
// Shared constants and types for the round-robin mux channel scheduler.
package mux_chan_sched_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CH_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    VALID  = 2'd2
  } state_t;

  function automatic logic [NCH-1:0] ch_onehot(input logic [CH_W-1:0] c);
    logic [NCH-1:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_chan_sched_rr_pick.sv
// Combinational request picker: round-robin from last+1, or fixed priority from ch0.
module rr_pick
  import mux_chan_sched_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] last,
  input  logic            rr_en,
  output logic [CH_W-1:0] win,
  output logic            any
);

  logic [CH_W-1:0] start;
  logic [CH_W-1:0] idx;
  logic            found;

  always_comb begin
    start = rr_en ? (last + 2'd1) : '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    // 2-bit index addition wraps mod 4, giving the ascending circular search
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = start + CH_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mux_chan_sched.sv
// Channel scheduler driving an external 4:1 data mux select and registering its output
// into a valid/ready stream, with a one-cycle grant back to the served source.
module mux_chan_sched
  import mux_chan_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter bit          RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [WIDTH-1:0] mux_o,
  output logic [CH_W-1:0]  ch,
  output logic [NCH-1:0]   grant,
  output logic [WIDTH-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t          state, state_nx;
  logic [CH_W-1:0] ch_nx;
  logic [CH_W-1:0] last;
  logic [CH_W-1:0] win;
  logic            any;

  rr_pick u_pick (
    .req   (req),
    .last  (last),
    .rr_en (RR_EN),
    .win   (win),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch       <= '0;
      out_data <= '0;
      out_ch   <= '0;
      last     <= '1;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
      // last updates at capture so the pick in VALID skips a lingering req bit
      if (state == SAMPLE) begin
        out_data <= mux_o;
        out_ch   <= ch;
        last     <= ch;
      end
    end
  end

  always_comb begin
    state_nx  = IDLE;
    ch_nx     = ch;
    grant     = '0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          ch_nx    = win;
          state_nx = SAMPLE;
        end else begin
          state_nx = IDLE;
        end
      end
      SAMPLE: begin
        grant    = ch_onehot(ch);
        state_nx = VALID;
      end
      VALID: begin
        out_valid = 1'b1;
        state_nx  = VALID;
        if (out_ready) begin
          if (any) begin
            ch_nx    = win;
            state_nx = SAMPLE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_chan_sched.sv
// Directed self-checking bench for mux_chan_sched (round-robin and fixed-priority instances).
module tb_mux_chan_sched;

  logic       clk;
  logic       rst;
  logic       out_ready;

  logic [3:0] req;
  logic [3:0] mux_o;
  logic [1:0] ch;
  logic [3:0] grant;
  logic [3:0] out_data;
  logic [1:0] out_ch;
  logic       out_valid;

  logic [3:0] req_fp;
  logic [3:0] mux_o_fp;
  logic [1:0] ch_fp;
  logic [3:0] grant_fp;
  logic [3:0] out_data_fp;
  logic [1:0] out_ch_fp;
  logic       out_valid_fp;

  int n_checks;
  int n_fail;

  // mux model: a=1 (ch0), b=2, c=3, d=4
  function automatic logic [3:0] mux_model(input logic [1:0] s);
    case (s)
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd3;
      default: return 4'd4;
    endcase
  endfunction

  assign mux_o    = mux_model(ch);
  assign mux_o_fp = mux_model(ch_fp);

  mux_chan_sched #(.WIDTH(4), .RR_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mux_o     (mux_o),
    .ch        (ch),
    .grant     (grant),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_chan_sched #(.WIDTH(4), .RR_EN(1'b0)) dut_fp (
    .clk       (clk),
    .rst       (rst),
    .req       (req_fp),
    .mux_o     (mux_o_fp),
    .ch        (ch_fp),
    .grant     (grant_fp),
    .out_data  (out_data_fp),
    .out_ch    (out_ch_fp),
    .out_valid (out_valid_fp),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    req_fp    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (ch !== 2'd0 || grant !== 4'b0000 || out_valid !== 1'b0 || out_data !== 4'd0 || out_ch !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: ch=%0d grant=%b valid=%b data=%0d out_ch=%0d, want 0 0000 0 0 0",
                 i, ch, grant, out_valid, out_data, out_ch);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    @(posedge clk); #1;
    n_checks++;
    if (ch !== 2'd2 || grant !== 4'b0100 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: ch=%0d grant=%b valid=%b, want 2 0100 0", ch, grant, out_valid);
    end
    @(posedge clk); #1;
    req = 4'b0000;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd3 || out_ch !== 2'd2 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_data: valid=%b data=%0d out_ch=%0d grant=%b, want 1 3 2 0000",
               out_valid, out_data, out_ch, grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_to_idle: valid=%b grant=%b, want 0 0000", out_valid, grant);
    end
  endtask

  task automatic test_round_robin();
    int         ord [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] g;
    logic [3:0] eg;
    logic       ev;
    int         k;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      eg = 4'b0000;
      if (c % 2 == 1) eg = 4'b0001 << ord[(c - 1) / 2];
      ev = (c % 2 == 0) && (c >= 2);
      n_checks++;
      if (grant !== eg || out_valid !== ev) begin
        n_fail++;
        $display("FAIL rr_order cyc%0d: grant=%b valid=%b, want %b %b", c, grant, out_valid, eg, ev);
      end
      if (ev) begin
        k = (c - 2) / 2;
        n_checks++;
        if (out_ch !== 2'(ord[k]) || out_data !== 4'(ord[k] + 1)) begin
          n_fail++;
          $display("FAIL rr_word%0d: out_ch=%0d data=%0d, want %0d %0d", k, out_ch, out_data, ord[k], ord[k] + 1);
        end
      end
      g = grant;
      @(posedge clk); #1;
      req = 4'b1111 & ~g;
    end
  endtask

  task automatic test_fixed_priority();
    int         ord [6] = '{1, 3, 1, 3, 1, 3};
    logic [3:0] g;
    logic [3:0] eg;
    logic       ev;
    int         k;
    do_reset();
    req_fp = 4'b1010;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      eg = 4'b0000;
      if (c % 2 == 1) eg = 4'b0001 << ord[(c - 1) / 2];
      ev = (c % 2 == 0) && (c >= 2);
      n_checks++;
      if (grant_fp !== eg || out_valid_fp !== ev) begin
        n_fail++;
        $display("FAIL fp_order cyc%0d: grant=%b valid=%b, want %b %b", c, grant_fp, out_valid_fp, eg, ev);
      end
      if (ev) begin
        k = (c - 2) / 2;
        n_checks++;
        if (out_ch_fp !== 2'(ord[k]) || out_data_fp !== 4'(ord[k] + 1)) begin
          n_fail++;
          $display("FAIL fp_word%0d: out_ch=%0d data=%0d, want %0d %0d", k, out_ch_fp, out_data_fp, ord[k], ord[k] + 1);
        end
      end
      g = grant_fp;
      @(posedge clk); #1;
      req_fp = 4'b1010 & ~g;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    req       = 4'b0010;
    @(posedge clk); #1;
    n_checks++;
    if (ch !== 2'd1 || grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_grant: ch=%0d grant=%b, want 1 0010", ch, grant);
    end
    @(posedge clk); #1;
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 4'd2 || out_ch !== 2'd1 || ch !== 2'd1 || grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: valid=%b data=%0d out_ch=%0d ch=%0d grant=%b, want 1 2 1 1 0000",
                 i, out_valid, out_data, out_ch, ch, grant);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    req = 4'b0000;
    n_checks++;
    if (out_valid !== 1'b0 || ch !== 2'd0 || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_accept: valid=%b ch=%0d grant=%b, want 0 0 0001", out_valid, ch, grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd1 || out_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_next_word: valid=%b data=%0d out_ch=%0d, want 1 1 0", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0100;
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_rst_sample: grant=%b, want 0100", grant);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'b0001;
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 4'b0000 || ch !== 2'd0 || out_data !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_rst_clear: valid=%b grant=%b ch=%0d data=%0d, want 0 0000 0 0",
               out_valid, grant, ch, out_data);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ch !== 2'd0 || grant !== 4'b0001 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_first: ch=%0d grant=%b valid=%b, want 0 0001 0", ch, grant, out_valid);
    end
    @(posedge clk); #1;
    req = 4'b0000;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd1 || out_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_rst_word: valid=%b data=%0d out_ch=%0d, want 1 1 0", out_valid, out_data, out_ch);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req       = '0;
    req_fp    = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
